// File: rtl/cen_frac_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// Optional feature macro used across this slice: CEN_FRAC_CNT_EN (per-channel pulse counters).
package cen_frac_pkg;

  // Default width of num/den/accumulator per channel
  localparam int W_DEFAULT = 16;

  // Lock FSM states
  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  // Low bit index of channel c in a packed bus of w-bit fields
  function automatic int slice_lo(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/cen_frac_ch.sv
// One fractional enable channel: captured num/den, phase accumulator and
// registered cen pulse. Optional macro CEN_FRAC_CNT_EN adds a 16-bit
// wrapping pulse counter that tracks cen exactly (counts pulses issued).
module cen_frac_ch
  import cen_frac_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_run,
  input  logic         hold,
  input  logic         load,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
`ifdef CEN_FRAC_CNT_EN
  output logic [15:0]  cnt,
`endif
  output logic         cen
);

  logic [W-1:0] num_r;
  logic [W-1:0] den_r;
  logic [W-1:0] acc_r;
  logic         cen_r;
  logic [W:0]   sum_s;
  logic [W:0]   diff_s;
  logic         ge_s;
  logic         den_zero_s;

  // Accumulator step computed one bit wider so acc+num never overflows
  always_comb begin
    sum_s      = {1'b0, acc_r} + {1'b0, num_r};
    diff_s     = sum_s - {1'b0, den_r};
    ge_s       = (sum_s >= {1'b0, den_r});
    den_zero_s = (den_r == {W{1'b0}});
  end

  // Config capture, accumulator update and registered enable pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_r <= {W{1'b0}};
      den_r <= {W{1'b0}};
      acc_r <= {W{1'b0}};
      cen_r <= 1'b0;
    end else if (load) begin
      num_r <= num;
      den_r <= den;
      acc_r <= {W{1'b0}};
      cen_r <= 1'b0;
    end else if (en_run && !hold) begin
      if (den_zero_s) begin
        cen_r <= 1'b0;
      end else if (ge_s) begin
        cen_r <= 1'b1;
        acc_r <= diff_s[W-1:0];
      end else begin
        cen_r <= 1'b0;
        acc_r <= sum_s[W-1:0];
      end
    end else begin
      // SETTLE keeps acc at its cleared value; hold freezes it in RUN
      cen_r <= 1'b0;
    end
  end

`ifdef CEN_FRAC_CNT_EN
  logic [15:0] cnt_r;

  // Pulse counter advances on the same edge that raises cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
    end else if (load) begin
      cnt_r <= 16'd0;
    end else if (en_run && !hold && !den_zero_s && ge_s) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
`endif

  assign cen = cen_r;

endmodule

// File: rtl/cen_frac_gen.sv
// Multi-channel fractional clock-enable generator with a settle/lock phase
// that mirrors PLL "locked" semantics after every reconfiguration.
// Optional macro CEN_FRAC_CNT_EN adds cnt_o, one 16-bit pulse counter per channel.
module cen_frac_gen
  import cen_frac_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int W           = W_DEFAULT,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [NUM_CH*W-1:0] num_i,
  input  logic [NUM_CH*W-1:0] den_i,
  input  logic                cfg_load_i,
  input  logic                hold_i,
  output logic [NUM_CH-1:0]   cen_o,
  output logic                locked_o,
`ifdef CEN_FRAC_CNT_EN
  output logic [NUM_CH*16-1:0] cnt_o,
`endif
  output logic [NUM_CH-1:0]   cfg_err_o
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_r;
  logic [CNT_W-1:0]  settle_cnt_r;
  logic              locked_r;
  logic [NUM_CH-1:0] cfg_err_r;
  logic [NUM_CH-1:0] den_zero_s;
  logic              en_run_s;

  // Flag channels whose incoming denominator is zero
  always_comb begin
    den_zero_s = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      den_zero_s[c] = (den_i[slice_lo(c, W) +: W] == {W{1'b0}});
    end
  end

  // Lock FSM: reload beats both hold and the SETTLE->RUN transition
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_SETTLE;
      settle_cnt_r <= {CNT_W{1'b0}};
      locked_r     <= 1'b0;
      cfg_err_r    <= {NUM_CH{1'b1}};
    end else if (cfg_load_i) begin
      state_r      <= ST_SETTLE;
      settle_cnt_r <= {CNT_W{1'b0}};
      locked_r     <= 1'b0;
      cfg_err_r    <= den_zero_s;
    end else begin
      case (state_r)
        ST_SETTLE: begin
          if (settle_cnt_r == CNT_LAST) begin
            state_r      <= ST_RUN;
            settle_cnt_r <= {CNT_W{1'b0}};
            locked_r     <= 1'b1;
          end else begin
            settle_cnt_r <= settle_cnt_r + CNT_ONE;
            locked_r     <= 1'b0;
          end
        end
        ST_RUN: begin
          locked_r <= 1'b1;
        end
        default: begin
          state_r      <= ST_SETTLE;
          settle_cnt_r <= {CNT_W{1'b0}};
          locked_r     <= 1'b0;
        end
      endcase
    end
  end

  assign en_run_s = (state_r == ST_RUN);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cen_frac_ch #(
      .W (W)
    ) u_ch (
      .clk    (clk_sys),
      .rst_n  (reset_n),
      .en_run (en_run_s),
      .hold   (hold_i),
      .load   (cfg_load_i),
      .num    (num_i[c*W +: W]),
      .den    (den_i[c*W +: W]),
`ifdef CEN_FRAC_CNT_EN
      .cnt    (cnt_o[c*16 +: 16]),
`endif
      .cen    (cen_o[c])
    );
  end

  assign locked_o  = locked_r;
  assign cfg_err_o = cfg_err_r;

endmodule
